sequencer: RTL
==============

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter w, default 8, data/address width in bits.
REQ-002 Parameter sel_w, default 4, register-select width in bits (low sel_w bits of i1..i3 are register indices).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_addr  output  w  fetch byte address (= pc).
REQ-006 mem_req  output  1  fetch request.
REQ-007 mem_ack  input  1  fetch acknowledge; mem_data valid in the same cycle.
REQ-008 mem_data  input  w  fetched instruction byte.
REQ-009 i1, i2, i3  output  w each  latched instruction arguments to the router.
REQ-010 alu_op  output  4  ALU operation code.
REQ-011 alu_zero  input  1  ALU zero flag for the current a/b.
REQ-012 reg_we  output  1  register-file write strobe for router z / z_sel.
REQ-013 z_src  output  1  0 = write ALU result, 1 = write i2 immediate.
REQ-014 halted  output  1  core stopped.
REQ-015 illegal  output  1  one-cycle pulse on undefined opcode.

Function
REQ-016 Each instruction is 4 bytes at pc..pc+3: opcode, i1, i2, i3.
REQ-017 States: F_OP, F_I1, F_I2, F_I3, EXEC, WB, HALT.
REQ-018 In F_* states mem_req = 1 and mem_addr = pc; both stable until mem_ack is sampled high.
REQ-019 On mem_ack in F_*: latch mem_data into opcode/i1/i2/i3 respectively, pc <= pc+1 mod 2^w, advance to the next state; no ack -> remain (unbounded wait).
REQ-020 mem_req = 0 in EXEC, WB, HALT.
REQ-021 After F_I3, EXEC lasts exactly one cycle with alu_op driven; alu_op = 0 outside EXEC.
REQ-022 Opcodes: 0x00 NOP; 0x01 ADD; 0x02 SUB; 0x03 AND; 0x04 OR; 0x05 XOR (alu_op = opcode[3:0]); 0x06 LDI; 0x07 JMP; 0x08 JZ; 0xFF HALT.
REQ-023 ADD..XOR: EXEC -> WB; in WB reg_we = 1, z_src = 0 for one cycle; WB -> F_OP.
REQ-024 LDI: EXEC -> WB with reg_we = 1, z_src = 1; alu_op = 0 during EXEC.
REQ-025 JMP: in EXEC pc <= i1; -> F_OP; no write.
REQ-026 JZ: in EXEC alu_op = 0x2 (SUB), alu_zero sampled; if 1, pc <= i1, else pc unchanged; -> F_OP.
REQ-027 NOP: EXEC -> F_OP.
REQ-028 HALT: EXEC -> HALT; halted = 1; HALT is left only by reset.
REQ-029 Undefined opcode: illegal = 1 during EXEC, otherwise treated as NOP.
REQ-030 Minimum latency per non-branch ALU instruction: 6 cycles with zero-wait memory (4 fetch + EXEC + WB); NOP/JMP/JZ: 5.
REQ-031 pc wrap: fetch at 0xFF followed by 0x00 without a fault.
REQ-032 reg_we and illegal are never asserted outside WB and EXEC respectively.
REQ-033 i1..i3 hold their values from the end of F_I3 until the next capture into the same register.

Reset
REQ-034 On rst_n low, immediately: state = F_OP, pc = 0, opcode/i1/i2/i3 = 0, alu_op = 0, reg_we = 0, z_src = 0, halted = 0, illegal = 0; mem_req goes high only after rst_n is released.
REQ-035 Reset asserted mid-fetch or in WB aborts the instruction; no partial write occurs.

Verification
REQ-036 Zero-wait memory with bytes 01 03 01 02 -> mem_addr 0,1,2,3; EXEC alu_op=1, i1=3, i2=1, i3=2; WB reg_we=1, z_src=0; next fetch at addr 4 in cycle 7.
REQ-037 mem_ack delayed 3 cycles on each byte -> mem_req/mem_addr held stable; bytes latched correctly; pc advances only on ack.
REQ-038 Program 08 10 00 00 with alu_zero=1 -> next fetch at 0x10; with alu_zero=0 -> next fetch at 0x04.
REQ-039 Opcode 0xFF -> halted=1, mem_req=0 indefinitely; opcode 0x3C -> illegal one-cycle pulse, no reg_we, fetch continues at pc+4.
REQ-040 Instruction placed at 0xFE -> bytes fetched from 0xFE, 0xFF, 0x00, 0x01; next fetch at 0x02.
REQ-041 rst_n pulsed low during F_I2 -> all outputs zero asynchronously, pc=0, fetch restarts at 0 after release.

Source files
------------

// File: rtl/sequencer.sv
// Byte-serial instruction sequencer: fetches 4-byte instructions (opcode, i1, i2, i3) from memory,
// drives the ALU/register-file controls for one EXEC cycle and an optional write-back cycle.
module sequencer #(
  parameter int unsigned w     = 8,
  parameter int unsigned sel_w = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [w-1:0] mem_addr,
  output logic         mem_req,
  input  logic         mem_ack,
  input  logic [w-1:0] mem_data,
  output logic [w-1:0] i1,
  output logic [w-1:0] i2,
  output logic [w-1:0] i3,
  output logic [3:0]   alu_op,
  input  logic         alu_zero,
  output logic         reg_we,
  output logic         z_src,
  output logic         halted,
  output logic         illegal
);

  // The router uses the low sel_w bits of i1..i3 as register indices.
  if (sel_w == 0 || sel_w > w) begin : g_bad_sel_w
    $error("sequencer: sel_w must be in 1..w");
  end

  localparam logic [w-1:0] OpNop  = w'(8'h00);
  localparam logic [w-1:0] OpAdd  = w'(8'h01);
  localparam logic [w-1:0] OpSub  = w'(8'h02);
  localparam logic [w-1:0] OpAnd  = w'(8'h03);
  localparam logic [w-1:0] OpOr   = w'(8'h04);
  localparam logic [w-1:0] OpXor  = w'(8'h05);
  localparam logic [w-1:0] OpLdi  = w'(8'h06);
  localparam logic [w-1:0] OpJmp  = w'(8'h07);
  localparam logic [w-1:0] OpJz   = w'(8'h08);
  localparam logic [w-1:0] OpHalt = w'(8'hFF);

  typedef enum logic [2:0] {
    StFetchOp,
    StFetchI1,
    StFetchI2,
    StFetchI3,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e       state_q, state_d;
  logic [w-1:0] pc_q, pc_d;
  logic [w-1:0] opcode_q, opcode_d;
  logic [w-1:0] i1_q, i1_d;
  logic [w-1:0] i2_q, i2_d;
  logic [w-1:0] i3_q, i3_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetchOp;
      pc_q     <= '0;
      opcode_q <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      i1_q     <= i1_d;
      i2_q     <= i2_d;
      i3_q     <= i3_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    i1_d     = i1_q;
    i2_d     = i2_q;
    i3_d     = i3_q;
    mem_req  = 1'b0;
    alu_op   = 4'h0;
    reg_we   = 1'b0;
    z_src    = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      StFetchOp, StFetchI1, StFetchI2, StFetchI3: begin
        // Gated by rst_n so the request cannot rise while reset is still held.
        mem_req = rst_n;
        if (mem_ack) begin
          pc_d = pc_q + 1'b1;
          case (state_q)
            StFetchOp: begin opcode_d = mem_data; state_d = StFetchI1; end
            StFetchI1: begin i1_d     = mem_data; state_d = StFetchI2; end
            StFetchI2: begin i2_d     = mem_data; state_d = StFetchI3; end
            default:   begin i3_d     = mem_data; state_d = StExec;    end
          endcase
        end
      end
      StExec: begin
        state_d = StFetchOp;
        case (opcode_q)
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            alu_op  = opcode_q[3:0];
            state_d = StWb;
          end
          OpLdi:  state_d = StWb;
          OpJmp:  pc_d = i1_q;
          OpJz: begin
            // Branch test is a SUB of the routed operands; only the zero flag matters.
            alu_op = 4'h2;
            if (alu_zero) pc_d = i1_q;
          end
          OpHalt: state_d = StHalt;
          OpNop:  ;
          default: illegal = 1'b1;
        endcase
      end
      StWb: begin
        reg_we  = 1'b1;
        z_src   = (opcode_q == OpLdi);
        state_d = StFetchOp;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetchOp;
    endcase
  end

  assign mem_addr = pc_q;
  assign i1       = i1_q;
  assign i2       = i2_q;
  assign i3       = i3_q;

endmodule
